// File: rtl/logo_anim_ctrl.sv
// ---------------------------------------------------------------------------
// logo_anim_ctrl
//
// Frame-synchronous animation sequencer for the VGA boot logo. It reveals the
// logo letters one at a time and then bounces the whole logo left and right,
// holding for a while at each end of travel. Every visible output changes only
// on a frame boundary, so the painters never draw a torn logo mid-frame.
//
// Ports
//   clk         in   1            system clock (single clock domain)
//   rst         in   1            asynchronous, active-high reset
//   frame_tick  in   1            frame-boundary strobe (level or pulse); only
//                                 its rising edge advances the sequencer
//   run         in   1            1 = animate, 0 = park at IDLE; sampled only on
//                                 frame edges
//   delt        out  11           horizontal offset handed to the letter painters
//   letter_en   out  NUM_LETTERS  per-letter paint enable, bit0 = first letter
//   scrolling   out  1            high while the logo is moving (SCROLL_R/SCROLL_L)
//   state_o     out  3            current state encoding, for debug visibility
//
// Parameters
//   NUM_LETTERS    number of letter painters gated by letter_en (>=1)
//   REVEAL_FRAMES  frames between successive letter reveals (>=1)
//   STEP           pixels moved per frame while scrolling (>=1, <=MAX_DELT)
//   MAX_DELT       right-hand offset limit (<=1502 so the logo stays on screen)
//   HOLD_FRAMES    frames held at each end of travel (>=1)
// ---------------------------------------------------------------------------
module logo_anim_ctrl #(
   parameter int NUM_LETTERS   = 4,
   parameter int REVEAL_FRAMES = 30,
   parameter int STEP          = 2,
   parameter int MAX_DELT      = 200,
   parameter int HOLD_FRAMES   = 60
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_tick,
   input  logic                   run,
   output logic [10:0]            delt,
   output logic [NUM_LETTERS-1:0] letter_en,
   output logic                   scrolling,
   output logic [2:0]             state_o
);

   // The frame counter is shared by all timed states, so it is sized for the
   // longer of the two intervals. It only ever counts 0 .. LIMIT-1.
   localparam int CNT_MAX = (REVEAL_FRAMES > HOLD_FRAMES) ? REVEAL_FRAMES : HOLD_FRAMES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]       REVEAL_LAST = CNT_W'(REVEAL_FRAMES - 1);
   localparam logic [CNT_W-1:0]       HOLD_LAST   = CNT_W'(HOLD_FRAMES - 1);
   localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(1);
   localparam logic [11:0]            STEP_12     = 12'(STEP);
   localparam logic [11:0]            MAX_12      = 12'(MAX_DELT);
   localparam logic [10:0]            STEP_11     = 11'(STEP);
   localparam logic [10:0]            MAX_11      = 11'(MAX_DELT);
   localparam logic [NUM_LETTERS-1:0] LETTER_ONE  = NUM_LETTERS'(1);
   localparam logic [NUM_LETTERS-1:0] LETTER_ALL  = '1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REVEAL   = 3'd1,
      SCROLL_R = 3'd2,
      HOLD_R   = 3'd3,
      SCROLL_L = 3'd4,
      HOLD_L   = 3'd5
   } state_t;

   state_t                 state_q,     state_d;
   logic [10:0]            delt_q,      delt_d;
   logic [NUM_LETTERS-1:0] letter_en_q, letter_en_d;
   logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
   logic                   tick_q,      tick_d;

   logic        fe;
   logic        state_legal;
   logic        reveal_expired;
   logic        hold_expired;
   logic [11:0] sum_r;

   // Rising-edge detect on frame_tick. tick_q resets high so a frame_tick that
   // is already high when reset releases is not mistaken for a new frame; a
   // level held for many clocks therefore yields exactly one event.
   assign fe = frame_tick & ~tick_q;

   // Encodings 6 and 7 are unreachable in normal operation; they are caught
   // here so an upset state register recovers to IDLE on the very next clock.
   assign state_legal = (3'(state_q) <= 3'd5);

   assign reveal_expired = (frame_cnt_q == REVEAL_LAST);
   assign hold_expired   = (frame_cnt_q == HOLD_LAST);

   // Rightward step is computed one bit wider than delt so the limit compare
   // cannot be fooled by a wrap, even with MAX_DELT near the top of the range.
   assign sum_r = {1'b0, delt_q} + STEP_12;

   // Next-state and next-output logic. Nothing moves unless a frame edge is
   // seen, which is what keeps the painters' inputs stable across a frame.
   always_comb begin
      state_d     = state_q;
      delt_d      = delt_q;
      letter_en_d = letter_en_q;
      frame_cnt_d = frame_cnt_q;
      tick_d      = frame_tick;

      if (!state_legal) begin
         state_d     = IDLE;
         delt_d      = '0;
         letter_en_d = '0;
         frame_cnt_d = '0;
      end else if (fe) begin
         if (!run) begin
            state_d     = IDLE;
            delt_d      = '0;
            letter_en_d = '0;
            frame_cnt_d = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_d     = REVEAL;
                  delt_d      = '0;
                  letter_en_d = LETTER_ONE;
                  frame_cnt_d = '0;
               end

               REVEAL: begin
                  if (reveal_expired) begin
                     frame_cnt_d = '0;
                     if (letter_en_q == LETTER_ALL) begin
                        state_d = SCROLL_R;
                     end else begin
                        letter_en_d = (letter_en_q << 1) | LETTER_ONE;
                     end
                  end else begin
                     frame_cnt_d = frame_cnt_q + CNT_ONE;
                  end
               end

               SCROLL_R: begin
                  if (sum_r >= MAX_12) begin
                     delt_d      = MAX_11;
                     state_d     = HOLD_R;
                     frame_cnt_d = '0;
                  end else begin
                     delt_d = sum_r[10:0];
                  end
               end

               HOLD_R: begin
                  if (hold_expired) begin
                     frame_cnt_d = '0;
                     state_d     = SCROLL_L;
                  end else begin
                     frame_cnt_d = frame_cnt_q + CNT_ONE;
                  end
               end

               SCROLL_L: begin
                  if (delt_q <= STEP_11) begin
                     delt_d      = '0;
                     state_d     = HOLD_L;
                     frame_cnt_d = '0;
                  end else begin
                     delt_d = delt_q - STEP_11;
                  end
               end

               HOLD_L: begin
                  if (hold_expired) begin
                     frame_cnt_d = '0;
                     state_d     = SCROLL_R;
                  end else begin
                     frame_cnt_d = frame_cnt_q + CNT_ONE;
                  end
               end

               default: begin
                  state_d     = IDLE;
                  delt_d      = '0;
                  letter_en_d = '0;
                  frame_cnt_d = '0;
               end
            endcase
         end
      end
   end

   // State and output registers. Reset is asynchronous so the logo blanks
   // immediately, without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         delt_q      <= '0;
         letter_en_q <= '0;
         frame_cnt_q <= '0;
         tick_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         delt_q      <= delt_d;
         letter_en_q <= letter_en_d;
         frame_cnt_q <= frame_cnt_d;
         tick_q      <= tick_d;
      end
   end

   assign delt      = delt_q;
   assign letter_en = letter_en_q;
   assign state_o   = state_q;
   assign scrolling = (state_q == SCROLL_R) || (state_q == SCROLL_L);

endmodule

// File: tb/tb_logo_anim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_logo_anim_ctrl
//
// Bench for the boot-logo animation sequencer, built with small timing
// parameters so a full reveal and bounce cycle takes only a couple of dozen
// frames. Expected output records are queued when a frame tick is driven and
// popped and compared once the sequencer has had its clock to respond.
// ---------------------------------------------------------------------------
module tb_logo_anim_ctrl;

   localparam int NUM_LETTERS   = 4;
   localparam int REVEAL_FRAMES = 2;
   localparam int STEP          = 3;
   localparam int MAX_DELT      = 10;
   localparam int HOLD_FRAMES   = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   frame_tick;
   logic                   run;
   logic [10:0]            delt;
   logic [NUM_LETTERS-1:0] letter_en;
   logic                   scrolling;
   logic [2:0]             state_o;

   typedef struct {
      logic                   run;
      logic [2:0]             st;
      logic [10:0]            delt;
      logic [NUM_LETTERS-1:0] le;
   } vec_t;

   vec_t vecs[22];
   vec_t sb_q[$];
   int   checks = 0;
   int   passed = 0;

   logo_anim_ctrl #(
      .NUM_LETTERS   (NUM_LETTERS),
      .REVEAL_FRAMES (REVEAL_FRAMES),
      .STEP          (STEP),
      .MAX_DELT      (MAX_DELT),
      .HOLD_FRAMES   (HOLD_FRAMES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .run        (run),
      .delt       (delt),
      .letter_en  (letter_en),
      .scrolling  (scrolling),
      .state_o    (state_o)
   );

   // 10 ns clock period
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input int st, input int d, input int le);
      vec_t v;
      v.run  = r;
      v.st   = 3'(st);
      v.delt = 11'(d);
      v.le   = NUM_LETTERS'(le);
      return v;
   endfunction

   // Single comparison; every check funnels through here.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Drive one frame edge with frame_tick held high for 'hold' clocks and
   // queue the outputs the sequencer should show afterwards.
   task automatic applyStimulus(input vec_t v, input int hold);
      run = v.run;
      sb_q.push_back(v);
      @(posedge clk);
      #1 frame_tick = 1'b1;
      repeat (hold) @(posedge clk);
      #1 frame_tick = 1'b0;
      @(negedge clk);
   endtask

   // Pop the oldest expectation and compare it with what the DUT shows now.
   task automatic popAndCheck(input string tag);
      vec_t v;
      if (sb_q.size() == 0) begin
         checks++;
         $display("[TB] FAIL %s.queue: got empty scoreboard, expected an entry", tag);
      end else begin
         v = sb_q.pop_front();
         checkOutput({tag, ".state"},     int'(state_o),   int'(v.st));
         checkOutput({tag, ".delt"},      int'(delt),      int'(v.delt));
         checkOutput({tag, ".letter_en"}, int'(letter_en), int'(v.le));
         checkOutput({tag, ".scrolling"}, int'(scrolling),
                     int'((v.st == 3'd2) || (v.st == 3'd4)));
      end
   endtask

   initial begin
      // Reveal then one full bounce, frame by frame
      vecs[0]  = mk(1, 1,  0, 4'h1);
      vecs[1]  = mk(1, 1,  0, 4'h1);
      vecs[2]  = mk(1, 1,  0, 4'h3);
      vecs[3]  = mk(1, 1,  0, 4'h3);
      vecs[4]  = mk(1, 1,  0, 4'h7);
      vecs[5]  = mk(1, 1,  0, 4'h7);
      vecs[6]  = mk(1, 1,  0, 4'hF);
      vecs[7]  = mk(1, 1,  0, 4'hF);
      vecs[8]  = mk(1, 2,  0, 4'hF);
      vecs[9]  = mk(1, 2,  3, 4'hF);
      vecs[10] = mk(1, 2,  6, 4'hF);
      vecs[11] = mk(1, 2,  9, 4'hF);
      vecs[12] = mk(1, 3, 10, 4'hF);
      vecs[13] = mk(1, 3, 10, 4'hF);
      vecs[14] = mk(1, 4, 10, 4'hF);
      vecs[15] = mk(1, 4,  7, 4'hF);
      vecs[16] = mk(1, 4,  4, 4'hF);
      vecs[17] = mk(1, 4,  1, 4'hF);
      vecs[18] = mk(1, 5,  0, 4'hF);
      vecs[19] = mk(1, 5,  0, 4'hF);
      vecs[20] = mk(1, 2,  0, 4'hF);
      vecs[21] = mk(1, 2,  3, 4'hF);

      // Reset with frame_tick high; outputs must clear with no clock edge yet
      rst        = 1'b1;
      frame_tick = 1'b1;
      run        = 1'b1;
      #3;
      checkOutput("rst_async.state",     int'(state_o),   0);
      checkOutput("rst_async.delt",      int'(delt),      0);
      checkOutput("rst_async.letter_en", int'(letter_en), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // frame_tick still high after release: no event may be seen
      repeat (4) @(negedge clk);
      checkOutput("rst_release.state",     int'(state_o),   0);
      checkOutput("rst_release.letter_en", int'(letter_en), 0);
      frame_tick = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i], 1);
         popAndCheck($sformatf("t%0d", i + 1));
      end

      // Drop run with no frame edge: nothing may change
      run = 1'b0;
      repeat (100) @(negedge clk);
      checkOutput("stop_hold.state",     int'(state_o),   2);
      checkOutput("stop_hold.delt",      int'(delt),      3);
      checkOutput("stop_hold.letter_en", int'(letter_en), 15);
      applyStimulus(mk(0, 0, 0, 0), 1);
      popAndCheck("stop");

      // Restart, then a tick held high for 5 clocks counts as a single frame
      applyStimulus(mk(1, 1, 0, 4'h1), 1);
      popAndCheck("restart");
      applyStimulus(mk(1, 1, 0, 4'h1), 5);
      popAndCheck("level_tick");
      applyStimulus(mk(1, 1, 0, 4'h3), 1);
      popAndCheck("after_level");

      // Same phase as t3 now, so replay t4..t16 to reach SCROLL_L with delt=7
      for (int i = 3; i <= 15; i++) begin
         applyStimulus(vecs[i], 1);
         popAndCheck($sformatf("replay_t%0d", i + 1));
      end

      // Pulse reset between clock edges while scrolling left
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_mid.state",     int'(state_o),   0);
      checkOutput("rst_mid.delt",      int'(delt),      0);
      checkOutput("rst_mid.letter_en", int'(letter_en), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(mk(1, 1, 0, 4'h1), 1);
      popAndCheck("post_rst");

      if (sb_q.size() != 0) begin
         checks++;
         $display("[TB] FAIL sb_drain: got %0d leftover entries, expected 0", sb_q.size());
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
